// File: rtl/dsp_sequencer.sv
// Per-frame program sequencer: fetches a stored program from instruction RAM, issues one
// instruction per clock to dsp_core, flushes the core pipeline with NOPs, then flags frame end.
module dsp_sequencer #(
    parameter int OPCODE_WIDTH      = 6,
    parameter int SAMPLE_ADDR_WIDTH = 10,
    parameter int PARAM_ADDR_WIDTH  = 10,
    parameter int PC_WIDTH          = 10,
    parameter int PIPELINE_DEPTH    = 4,
    parameter int INSTR_WIDTH       = OPCODE_WIDTH + SAMPLE_ADDR_WIDTH + PARAM_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         sample_tick,
    input  logic [PC_WIDTH:0]            program_length,
    output logic                         imem_rd_en,
    output logic [PC_WIDTH-1:0]          imem_rd_addr,
    input  logic [INSTR_WIDTH-1:0]       imem_rd_data,
    output logic [OPCODE_WIDTH-1:0]      instr_opcode,
    output logic [SAMPLE_ADDR_WIDTH-1:0] instr_sample_addr,
    output logic [PARAM_ADDR_WIDTH-1:0]  instr_param_addr,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun,
    input  logic                         clear_overrun,
    output logic [15:0]                  frame_count
);

    localparam int CNT_W_RAW = $clog2(PIPELINE_DEPTH + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIPELINE_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic [PC_WIDTH-1:0]  pc, pc_nxt;
    logic [PC_WIDTH:0]    len, len_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 rd_en_nxt;
    logic [PC_WIDTH-1:0]  rd_addr_nxt;
    logic                 busy_nxt, done_nxt, ovr_nxt;
    logic [15:0]          count_nxt;
    logic                 vld_p1;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        len_nxt     = len;
        cnt_nxt     = cnt;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = '0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        count_nxt   = frame_count;
        ovr_nxt     = overrun;

        case (state)
            // DONE lasts one cycle and accepts a new frame tick exactly like IDLE.
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (sample_tick && enable) begin
                    if (program_length != '0) begin
                        state_nxt = RUN;
                        len_nxt   = program_length;
                        pc_nxt    = '0;
                        rd_en_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        count_nxt = frame_count + 16'd1;
                    end
                end
            end
            RUN: begin
                busy_nxt = 1'b1;
                if ({1'b0, pc} == len - 1'b1) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    pc_nxt      = pc + 1'b1;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = pc + 1'b1;
                end
            end
            DRAIN: begin
                // One cycle for the last RAM read to land, then PIPELINE_DEPTH core flush cycles.
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    count_nxt = frame_count + 16'd1;
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    busy_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if ((state == RUN || state == DRAIN) && sample_tick) begin
            ovr_nxt = 1'b1;
        end else if (clear_overrun) begin
            ovr_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= '0;
            len          <= '0;
            cnt          <= '0;
            imem_rd_en   <= 1'b0;
            imem_rd_addr <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            frame_count  <= '0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            len          <= len_nxt;
            cnt          <= cnt_nxt;
            imem_rd_en   <= rd_en_nxt;
            imem_rd_addr <= rd_addr_nxt;
            busy         <= busy_nxt;
            frame_done   <= done_nxt;
            overrun      <= ovr_nxt;
            frame_count  <= count_nxt;
        end
    end

    // p1: RAM data arrives one cycle after the read; issue it, else a NOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1            <= 1'b0;
            instr_opcode      <= '0;
            instr_sample_addr <= '0;
            instr_param_addr  <= '0;
        end else begin
            vld_p1 <= imem_rd_en;
            if (vld_p1) begin
                instr_opcode      <= imem_rd_data[INSTR_WIDTH-1 -: OPCODE_WIDTH];
                instr_sample_addr <= imem_rd_data[PARAM_ADDR_WIDTH +: SAMPLE_ADDR_WIDTH];
                instr_param_addr  <= imem_rd_data[PARAM_ADDR_WIDTH-1:0];
            end else begin
                instr_opcode      <= '0;
                instr_sample_addr <= '0;
                instr_param_addr  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_sequencer.sv
// Bench for dsp_sequencer: directed and random frames checked against a frame-timeline model.
module tb_dsp_sequencer;

    localparam int PD = 4;

    logic        clk = 1'b0;
    logic        reset, enable, sample_tick, clear_overrun;
    logic [10:0] program_length;
    logic        imem_rd_en;
    logic [9:0]  imem_rd_addr;
    logic [25:0] imem_rd_data = '0;
    logic [5:0]  instr_opcode;
    logic [9:0]  instr_sample_addr, instr_param_addr;
    logic        busy, frame_done, overrun;
    logic [15:0] frame_count;

    logic [25:0] mem [0:1023];

    int checks = 0;
    int passes = 0;

    // Model: at most one frame record; outputs derived from its start edge and length.
    int          n = 0;
    bit          m_act = 0;
    int          m_t0, m_len, m_done;
    bit          m_ovr = 0;
    logic [15:0] m_fc = '0;

    dsp_sequencer #(
        .OPCODE_WIDTH(6), .SAMPLE_ADDR_WIDTH(10), .PARAM_ADDR_WIDTH(10),
        .PC_WIDTH(10), .PIPELINE_DEPTH(PD), .INSTR_WIDTH(26)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
        .program_length(program_length), .imem_rd_en(imem_rd_en),
        .imem_rd_addr(imem_rd_addr), .imem_rd_data(imem_rd_data),
        .instr_opcode(instr_opcode), .instr_sample_addr(instr_sample_addr),
        .instr_param_addr(instr_param_addr), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .clear_overrun(clear_overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rd_data <= mem[imem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s edge %0d: got %0h expected %0h", tag, n, obs, exp);
    endtask

    task automatic step(input bit r, input bit tk, input bit en, input int pl, input bit clr);
        logic [25:0] w;
        bit          e_rd, e_busy, e_fd;
        logic [9:0]  e_addr;
        logic [25:0] e_ins;
        reset = r; sample_tick = tk; enable = en; program_length = 11'(pl); clear_overrun = clr;
        @(posedge clk);
        n++;
        if (r) begin
            m_act = 0; m_ovr = 0; m_fc = '0;
        end else begin
            if (m_act && n > m_t0 && n <= m_done && tk) m_ovr = 1;
            else begin
                if (clr) m_ovr = 0;
                if (tk && en) begin
                    m_act = 1; m_t0 = n; m_len = pl;
                    m_done = (pl == 0) ? n : n + pl + 1 + PD;
                end
            end
            if (m_act && n == m_done) m_fc = m_fc + 16'd1;
        end
        e_rd   = m_act && m_len > 0 && n >= m_t0 && n <= m_t0 + m_len - 1;
        e_addr = e_rd ? 10'(n - m_t0) : 10'd0;
        e_ins  = (m_act && m_len > 0 && n >= m_t0 + 2 && n <= m_t0 + m_len + 1)
                 ? mem[n - m_t0 - 2] : 26'd0;
        e_busy = m_act && n >= m_t0 && n < m_done;
        e_fd   = m_act && n == m_done;
        #1;
        w = {instr_opcode, instr_sample_addr, instr_param_addr};
        chk("rd_en", 32'(imem_rd_en), 32'(e_rd));
        chk("rd_addr", 32'(imem_rd_addr), 32'(e_addr));
        chk("instr", 32'(w), 32'(e_ins));
        if (!(m_act && m_len == 0 && n == m_done)) chk("busy", 32'(busy), 32'(e_busy));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 1, 3, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 26'($urandom);
        mem[0] = {6'd1, 10'd5, 10'd7};
        mem[1] = {6'd2, 10'd6, 10'd8};
        mem[2] = {6'd4, 10'd9, 10'd0};

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(2);

        // Basic three-instruction frame
        step(0, 1, 1, 3, 0);
        idle(11);

        // Overrun: second tick three edges in, cleared later
        step(0, 1, 1, 3, 0);
        idle(2);
        step(0, 1, 1, 3, 0);
        idle(6);
        step(0, 0, 1, 3, 1);
        idle(3);

        // Set and clear on the same edge
        step(0, 1, 1, 3, 0);
        step(0, 1, 1, 3, 1);
        idle(10);
        step(0, 0, 1, 3, 1);

        // Back-to-back: second tick sampled in the DONE cycle, length changes mid-frame
        step(0, 1, 1, 2, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 7, 0);
        step(0, 1, 1, 2, 0);
        idle(10);

        // Empty program, then disabled tick
        step(0, 1, 1, 0, 0);
        idle(3);
        step(0, 1, 0, 3, 0);
        idle(3);

        // Reset mid-frame, then a clean frame
        step(0, 1, 1, 3, 0);
        idle(2);
        step(1, 0, 1, 3, 0);
        idle(2);
        step(0, 1, 1, 3, 0);
        idle(10);

        // Randomized traffic
        for (int i = 0; i < 16; i++) mem[i] = 26'($urandom);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99, 0) == 0), ($urandom_range(5, 0) == 0),
                 ($urandom_range(7, 0) != 0), int'($urandom_range(8, 0)),
                 ($urandom_range(9, 0) == 0));
        end
        idle(12);

        // Counter wrap: 65535 empty frames, each tick landing in the previous DONE cycle
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 65535; i++) step(0, 1, 1, 0, 0);
        idle(1);
        chk("fc_preload", 32'(frame_count), 32'hFFFF);
        step(0, 1, 1, 0, 0);
        chk("fc_wrap", 32'(frame_count), 32'h0000);
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
